// File: rtl/kamikaze_pipe_ctrl_pkg.sv
// Shared types and encodings for the kamikaze decode/execute/writeback sequencing controller.
// Forward-select encodings, FSM state codes and the forwarding priority function.
package kamikaze_pipe_ctrl_pkg;

  localparam int RF_AW_DEF = 5;
  localparam int MC_CW_DEF = 3;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_WB = 2'b10;

  typedef enum logic [0:0] {
    PC_ST_RUN = 1'b0,
    PC_ST_MC  = 1'b1
  } pc_state_e;

  // EX wins over WB because it holds the younger write; a load in EX has no result yet
  function automatic logic [1:0] fwd_select(input logic id_valid, input logic ex_hit,
                                            input logic ex_load, input logic wb_hit);
    logic [1:0] sel;
    if (!id_valid) begin
      sel = FWD_RF;
    end else if (ex_hit && !ex_load) begin
      sel = FWD_EX;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/kamikaze_pipe_ctrl_if.sv
// Decode-side instruction fields and pipeline control outputs of the sequencing controller.
// The master side is the decode/datapath driver, the slave side is the controller.
interface kamikaze_pipe_ctrl_if #(
  parameter int RF_AW = 5,
  parameter int MC_CW = 3
);
  logic             id_valid_i;
  logic [RF_AW-1:0] id_rs1_i;
  logic [RF_AW-1:0] id_rs2_i;
  logic             id_rs1_use_i;
  logic             id_rs2_use_i;
  logic [RF_AW-1:0] id_rd_i;
  logic             id_rd_we_i;
  logic             id_is_load_i;
  logic [MC_CW-1:0] id_mc_len_i;
  logic             redirect_i;
  logic             stall_o;
  logic             issue_o;
  logic             ex_hold_o;
  logic             id_kill_o;
  logic [1:0]       fwd1_sel_o;
  logic [1:0]       fwd2_sel_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
           id_rd_i, id_rd_we_i, id_is_load_i, id_mc_len_i, redirect_i,
    input  stall_o, issue_o, ex_hold_o, id_kill_o, fwd1_sel_o, fwd2_sel_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_rs1_use_i, id_rs2_use_i,
           id_rd_i, id_rd_we_i, id_is_load_i, id_mc_len_i, redirect_i,
    output stall_o, issue_o, ex_hold_o, id_kill_o, fwd1_sel_o, fwd2_sel_o
  );
endinterface

// File: rtl/kamikaze_hazard_cmp.sv
// Compares one in-flight scoreboard slot against one decode source operand.
// x0 is hardwired zero, so it never produces a hit.
module kamikaze_hazard_cmp #(
  parameter int RF_AW = 5
) (
  input  logic             slot_v,
  input  logic             slot_we,
  input  logic [RF_AW-1:0] slot_rd,
  input  logic [RF_AW-1:0] src,
  input  logic             src_use,
  output logic             hit
);

  assign hit = slot_v & slot_we & src_use & (slot_rd != {RF_AW{1'b0}}) & (slot_rd == src);

endmodule

// File: rtl/kamikaze_pipe_ctrl.sv
// Pipeline sequencing controller: EX/WB destination scoreboard, operand forwarding selects,
// load-use and multi-cycle stalls, and branch-redirect flush of the decode stage.
module kamikaze_pipe_ctrl
  import kamikaze_pipe_ctrl_pkg::*;
#(
  parameter int RF_AW = RF_AW_DEF,
  parameter int MC_CW = MC_CW_DEF
) (
  input logic                clk_i,
  input logic                rst_i,
  kamikaze_pipe_ctrl_if.slave pif
);

  localparam logic [MC_CW-1:0] CNT_ONE  = MC_CW'(1);
  localparam logic [MC_CW-1:0] CNT_ZERO = {MC_CW{1'b0}};

  pc_state_e        state_r;
  pc_state_e        state_nxt_s;
  logic [MC_CW-1:0] cnt_r;
  logic [MC_CW-1:0] cnt_nxt_s;

  logic             ex_v_r;
  logic             ex_we_r;
  logic             ex_ld_r;
  logic [RF_AW-1:0] ex_rd_r;
  logic             wb_v_r;
  logic             wb_we_r;
  logic [RF_AW-1:0] wb_rd_r;

  logic ex_hit1_s, ex_hit2_s, wb_hit1_s, wb_hit2_s;
  logic load_use_s;
  logic issue_s, stall_s, hold_s, kill_s;

  kamikaze_hazard_cmp #(.RF_AW(RF_AW)) u_cmp_ex1 (
    .slot_v(ex_v_r), .slot_we(ex_we_r), .slot_rd(ex_rd_r),
    .src(pif.id_rs1_i), .src_use(pif.id_rs1_use_i), .hit(ex_hit1_s)
  );
  kamikaze_hazard_cmp #(.RF_AW(RF_AW)) u_cmp_ex2 (
    .slot_v(ex_v_r), .slot_we(ex_we_r), .slot_rd(ex_rd_r),
    .src(pif.id_rs2_i), .src_use(pif.id_rs2_use_i), .hit(ex_hit2_s)
  );
  kamikaze_hazard_cmp #(.RF_AW(RF_AW)) u_cmp_wb1 (
    .slot_v(wb_v_r), .slot_we(wb_we_r), .slot_rd(wb_rd_r),
    .src(pif.id_rs1_i), .src_use(pif.id_rs1_use_i), .hit(wb_hit1_s)
  );
  kamikaze_hazard_cmp #(.RF_AW(RF_AW)) u_cmp_wb2 (
    .slot_v(wb_v_r), .slot_we(wb_we_r), .slot_rd(wb_rd_r),
    .src(pif.id_rs2_i), .src_use(pif.id_rs2_use_i), .hit(wb_hit2_s)
  );

  assign load_use_s = pif.id_valid_i & ex_ld_r & (ex_hit1_s | ex_hit2_s);

  // Next-state and control decode; outputs are forced idle while reset is asserted
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    issue_s     = 1'b0;
    stall_s     = 1'b0;
    hold_s      = 1'b0;
    kill_s      = 1'b0;
    if (rst_i) begin
      state_nxt_s = PC_ST_RUN;
      cnt_nxt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        PC_ST_RUN: begin
          if (pif.redirect_i) begin
            kill_s = 1'b1;
          end else if (load_use_s) begin
            stall_s = 1'b1;
          end else begin
            issue_s = pif.id_valid_i;
          end
          if (issue_s && (pif.id_mc_len_i != CNT_ZERO)) begin
            cnt_nxt_s   = pif.id_mc_len_i;
            state_nxt_s = PC_ST_MC;
          end else begin
            cnt_nxt_s   = cnt_r;
            state_nxt_s = PC_ST_RUN;
          end
        end
        PC_ST_MC: begin
          // redirect_i is deliberately not looked at while the EX op is busy
          hold_s    = 1'b1;
          stall_s   = 1'b1;
          cnt_nxt_s = cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            state_nxt_s = PC_ST_RUN;
          end else begin
            state_nxt_s = PC_ST_MC;
          end
        end
        default: begin
          state_nxt_s = PC_ST_RUN;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end
  end

  // FSM state and multi-cycle busy counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= PC_ST_RUN;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Scoreboard slots: WB takes a bubble while EX is held, otherwise both advance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_v_r  <= 1'b0;
      ex_we_r <= 1'b0;
      ex_ld_r <= 1'b0;
      ex_rd_r <= {RF_AW{1'b0}};
      wb_v_r  <= 1'b0;
      wb_we_r <= 1'b0;
      wb_rd_r <= {RF_AW{1'b0}};
    end else if (hold_s) begin
      wb_v_r  <= 1'b0;
      wb_we_r <= 1'b0;
      wb_rd_r <= {RF_AW{1'b0}};
    end else begin
      wb_v_r  <= ex_v_r;
      wb_we_r <= ex_we_r;
      wb_rd_r <= ex_rd_r;
      if (issue_s) begin
        ex_v_r  <= 1'b1;
        ex_we_r <= pif.id_rd_we_i;
        ex_ld_r <= pif.id_is_load_i;
        ex_rd_r <= pif.id_rd_i;
      end else begin
        ex_v_r  <= 1'b0;
        ex_we_r <= 1'b0;
        ex_ld_r <= 1'b0;
        ex_rd_r <= {RF_AW{1'b0}};
      end
    end
  end

  assign pif.stall_o    = stall_s;
  assign pif.issue_o    = issue_s;
  assign pif.ex_hold_o  = hold_s;
  assign pif.id_kill_o  = kill_s;
  assign pif.fwd1_sel_o = fwd_select(pif.id_valid_i, ex_hit1_s, ex_ld_r, wb_hit1_s);
  assign pif.fwd2_sel_o = fwd_select(pif.id_valid_i, ex_hit2_s, ex_ld_r, wb_hit2_s);

endmodule

// File: doc/kamikaze_pipe_ctrl.md
Name: kamikaze_pipe_ctrl

Overview:
Pipeline sequencing controller for the decode→execute→writeback path of the kamikaze core. Tracks destination registers in flight in EX and WB and drives operand-forwarding selects for both ALU operands. Generates load-use and multi-cycle stalls, bubble insertion and branch-redirect flush. Sits beside the execute stage; purely control, no data buses.

Parameters:
RF_AW, 5, register-file address width
MC_CW, 3, width of multi-cycle length field / busy counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
id_valid_i  in  1  decode holds a valid instruction
id_rs1_i  in  RF_AW  source 1 address
id_rs2_i  in  RF_AW  source 2 address
id_rs1_use_i  in  1  instruction reads rs1
id_rs2_use_i  in  1  instruction reads rs2 (register operand, not immediate)
id_rd_i  in  RF_AW  destination address
id_rd_we_i  in  1  instruction writes rd
id_is_load_i  in  1  result available only after WB
id_mc_len_i  in  MC_CW  extra EX cycles required (0 = single-cycle)
redirect_i  in  1  EX instruction resolved a taken branch/jump
stall_o  out  1  freeze PC and IF/ID registers
issue_o  out  1  ID instruction enters EX this cycle
ex_hold_o  out  1  freeze EX stage registers
id_kill_o  out  1  discard IF/ID contents (flush)
fwd1_sel_o  out  2  op1 source: 00 RF, 01 EX result, 10 WB result
fwd2_sel_o  out  2  op2 source, same encoding

Behaviour:
- Reset (async, rst_i=1): all scoreboard valid bits 0, counter 0, state RUN; outputs stall_o=0, issue_o=0, ex_hold_o=0, id_kill_o=0, fwd*_sel_o=00. Reset mid multi-cycle op aborts it immediately.
- Scoreboard: EX slot {v, rd, we, load}, WB slot {v, rd, we}. A slot "hits" rsN when v & we & rd!=0 & rd==rsN & rsN_use.
- Forwarding (combinational from current ID and slots): EX hit (non-load) → 01; else WB hit → 10; else 00. x0 never forwarded. EX has priority over WB.
- Load-use: EX slot is load and hits either used source → stall_o=1, issue_o=0, bubble into EX for one cycle; next cycle operand resolves via WB forward (10).
- FSM states RUN, MC_BUSY.
  - RUN: issue_o = id_valid_i & !stall & !redirect_i. If issued with id_mc_len_i=N>0: counter←N, go MC_BUSY.
  - MC_BUSY: ex_hold_o=1, stall_o=1, issue_o=0, WB slot receives bubble each cycle; counter decrements; when counter==1 decrement to 0 and return to RUN (EX instruction moves to WB on the next advance). Total EX occupancy = N+1 cycles.
- Slot advance (when ex_hold_o=0): WB←EX; EX←issued ID fields, or bubble (v=0) if not issued.
- Redirect: sampled only in RUN. redirect_i=1 → id_kill_o=1, issue_o=0, EX receives bubble; has priority over load-use stall (stall_o=0 that cycle). In MC_BUSY redirect_i is ignored.
- id_valid_i=0: no stall generated, bubble into EX.
- Forward selects are 00 whenever id_valid_i=0.

Decomposition:
- riscv_defines.v gains FWD_RF/FWD_EX/FWD_WB encodings and PC_ST_RUN/PC_ST_MC state codes.
- One natural sub-module: kamikaze_hazard_cmp (combinational slot-vs-source hit compare, instantiated per slot/source pair).

Test Plan:
- Reset mid MC_BUSY (id_mc_len_i=5, rst_i at count 3) → all outputs 0, state RUN next cycle.
- Back-to-back ADD x5 then ADD x6,x5,x5 → fwd1_sel_o=fwd2_sel_o=01, no stall; third instr reading x5 one gap later → 10.
- Load x7 then use x7 → one cycle stall_o=1, issue_o=0; following cycle fwd sel=10, issue_o=1.
- Write x0 then read x0 → fwd sels 00, no stall.
- id_mc_len_i=3 issued → ex_hold_o=1 and stall_o=1 for exactly 3 cycles, redirect_i pulsed during them ignored.
- redirect_i=1 coincident with load-use hazard → id_kill_o=1, stall_o=0, issue_o=0, EX bubble.
